// File: rtl/lbp_stream.sv
// lbp_stream: streaming 3x3 Local Binary Pattern engine.
// Every gray pixel is fetched once in raster order. Two column-indexed line
// buffers and a 3x3 window rebuild each neighbourhood. One 8-bit code is
// written per emitted center pixel.
module lbp_stream #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int DW     = 8,
  parameter int AW     = 14,
  parameter int BORDER = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;

  localparam logic [AW-1:0] P_LAST      = AW'(IMG_W * IMG_H - 1);
  localparam logic [AW-1:0] Q_OFS       = AW'(IMG_W + 1);
  localparam logic [AW-1:0] DRAIN_FIRST = AW'(IMG_W * IMG_H - IMG_W - 1);
  localparam logic [CW-1:0] COL_LAST    = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_r;
  logic [AW-1:0] p_r;          // fetch index
  logic          vld_d_r;      // a pixel is on gray_data this cycle
  logic [CW-1:0] col_r;        // column of the arriving pixel
  logic [RW-1:0] row_r;        // row of the arriving pixel
  logic [AW-1:0] in_p_r;       // raster index of the arriving pixel
  logic [AW-1:0] drain_q_r;    // next zero-coded center during drain

  logic [DW-1:0] lb_a_r [IMG_W];   // previous row, by column
  logic [DW-1:0] lb_b_r [IMG_W];   // two rows back, by column
  logic [DW-1:0] win_r  [3][3];    // [row][col], row 0 on top
  logic [DW-1:0] win_nxt_s [3][3];

  logic          accept_s;
  logic          interior_s;
  logic          emit_any_s;
  logic [AW-1:0] q_s;
  logic [7:0]    code_s;

  // Code bit set when the neighbour is not smaller than the center.
  function automatic logic [7:0] lbp_code(
    input logic [DW-1:0] c,
    input logic [DW-1:0] n0, input logic [DW-1:0] n1,
    input logic [DW-1:0] n2, input logic [DW-1:0] n3,
    input logic [DW-1:0] n4, input logic [DW-1:0] n5,
    input logic [DW-1:0] n6, input logic [DW-1:0] n7
  );
    return {n7 >= c, n6 >= c, n5 >= c, n4 >= c,
            n3 >= c, n2 >= c, n1 >= c, n0 >= c};
  endfunction

  assign accept_s  = (state_r == READ) && gray_ready;
  assign gray_req  = accept_s;
  assign gray_addr = p_r;

  // The center sits one row up and one column left of the arriving pixel.
  // A column-0 arrival places the center in the last column of an earlier
  // row, so it is never interior. This is what blanks row-straddling windows.
  assign interior_s = (col_r >= CW'(2)) && (row_r >= RW'(2));
  assign emit_any_s = (in_p_r >= Q_OFS);
  assign q_s        = in_p_r - Q_OFS;

  // Next window: shift left, new right column from line buffers and input.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_nxt_s[i][0] = win_r[i][1];
      win_nxt_s[i][1] = win_r[i][2];
    end
    win_nxt_s[0][2] = lb_b_r[col_r];
    win_nxt_s[1][2] = lb_a_r[col_r];
    win_nxt_s[2][2] = gray_data;
    code_s = lbp_code(win_nxt_s[1][1],
                      win_nxt_s[0][0], win_nxt_s[0][1], win_nxt_s[0][2],
                      win_nxt_s[1][0], win_nxt_s[1][2],
                      win_nxt_s[2][0], win_nxt_s[2][1], win_nxt_s[2][2]);
  end

  // Line buffers and window advance only on a real data slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb_a_r[i] <= '0;
        lb_b_r[i] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_r[i][j] <= '0;
        end
      end
    end else if (vld_d_r) begin
      lb_b_r[col_r] <= lb_a_r[col_r];
      lb_a_r[col_r] <= gray_data;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_r[i][j] <= win_nxt_s[i][j];
        end
      end
    end
  end

  // Control FSM, fetch/position counters and registered LBP outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      p_r       <= '0;
      vld_d_r   <= 1'b0;
      col_r     <= '0;
      row_r     <= '0;
      in_p_r    <= '0;
      drain_q_r <= DRAIN_FIRST;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= 8'h00;
      finish    <= 1'b0;
    end else begin
      lbp_valid <= 1'b0;
      vld_d_r   <= accept_s;

      if (vld_d_r) begin
        if (interior_s) begin
          lbp_valid <= 1'b1;
          lbp_addr  <= q_s;
          lbp_data  <= code_s;
        end else if ((BORDER != 0) && emit_any_s) begin
          lbp_valid <= 1'b1;
          lbp_addr  <= q_s;
          lbp_data  <= 8'h00;
        end
        if (col_r == COL_LAST) begin
          col_r <= '0;
          if (row_r != ROW_LAST) row_r <= row_r + RW'(1);
        end else begin
          col_r <= col_r + CW'(1);
        end
        if (in_p_r != P_LAST) in_p_r <= in_p_r + AW'(1);
      end

      case (state_r)
        IDLE: begin
          if (gray_ready) state_r <= READ;
        end
        READ: begin
          if (accept_s) begin
            if (p_r == P_LAST) state_r <= DRAIN;
            else               p_r     <= p_r + AW'(1);
          end
        end
        DRAIN: begin
          if (vld_d_r) begin
            // Final pixel is being coded now; without a border tail we are done.
            if (BORDER == 0) state_r <= DONE;
          end else if (BORDER != 0) begin
            lbp_valid <= 1'b1;
            lbp_addr  <= drain_q_r;
            lbp_data  <= 8'h00;
            if (drain_q_r == P_LAST) state_r   <= DONE;
            else                     drain_q_r <= drain_q_r + AW'(1);
          end else begin
            state_r <= DONE;
          end
        end
        DONE: begin
          finish <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_stream.sv
// tb_lbp_stream: directed checks of lbp_stream on four configurations.
// 0: 4x4 BORDER=0, 1: 4x4 BORDER=1, 2: 8x8 BORDER=0, 3: 128x128 default.
module tb_lbp_stream;

  typedef struct {
    int inst;
    int addr;
    int data;
    int cyc;
  } strobe_t;

  logic        clk = 1'b0;
  logic        rst   [4];
  logic        rdy   [4];
  logic        req   [4];
  logic [13:0] gaddr [4];
  logic [7:0]  gdata [4];
  logic        lv    [4];
  logic [13:0] la    [4];
  logic [7:0]  ld    [4];
  logic        fin   [4];

  logic [7:0]  mem [4][16384];
  strobe_t     log_q[$];
  int          fin_cyc  [4];
  int          req0_cyc [4];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
  int          dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

  always #5 clk = ~clk;

  lbp_stream #(.IMG_W(4), .IMG_H(4), .DW(8), .AW(14), .BORDER(0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .gray_ready(rdy[0]), .gray_req(req[0]),
    .gray_addr(gaddr[0]), .gray_data(gdata[0]), .lbp_valid(lv[0]),
    .lbp_addr(la[0]), .lbp_data(ld[0]), .finish(fin[0]));
  lbp_stream #(.IMG_W(4), .IMG_H(4), .DW(8), .AW(14), .BORDER(1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .gray_ready(rdy[1]), .gray_req(req[1]),
    .gray_addr(gaddr[1]), .gray_data(gdata[1]), .lbp_valid(lv[1]),
    .lbp_addr(la[1]), .lbp_data(ld[1]), .finish(fin[1]));
  lbp_stream #(.IMG_W(8), .IMG_H(8), .DW(8), .AW(14), .BORDER(0)) u_dut2 (
    .clk(clk), .reset(rst[2]), .gray_ready(rdy[2]), .gray_req(req[2]),
    .gray_addr(gaddr[2]), .gray_data(gdata[2]), .lbp_valid(lv[2]),
    .lbp_addr(la[2]), .lbp_data(ld[2]), .finish(fin[2]));
  lbp_stream u_dut3 (
    .clk(clk), .reset(rst[3]), .gray_ready(rdy[3]), .gray_req(req[3]),
    .gray_addr(gaddr[3]), .gray_data(gdata[3]), .lbp_valid(lv[3]),
    .lbp_addr(la[3]), .lbp_data(ld[3]), .finish(fin[3]));

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Gray memory model: one-cycle read latency.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (req[k] === 1'b1) gdata[k] <= mem[k][gaddr[k]];
    end
  end

  // Strobe, first-request and finish monitor.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (lv[k] === 1'b1) log_q.push_back('{k, int'(la[k]), int'(ld[k]), cyc});
      if (fin[k] === 1'b1 && fin_cyc[k] < 0) fin_cyc[k] = cyc;
      if (req[k] === 1'b1 && req0_cyc[k] < 0) req0_cyc[k] = cyc;
    end
  end

  // Direct 8x8 neighbourhood reference.
  function automatic logic [7:0] ref_code(input int k, input int r, input int c);
    logic [7:0] code;
    logic [7:0] ctr;
    ctr = mem[k][r * 8 + c];
    for (int b = 0; b < 8; b++) code[b] = (mem[k][(r + dr[b]) * 8 + c + dc[b]] >= ctr);
    return code;
  endfunction

  task automatic start_frame(input int k);
    rst[k] = 1'b1;
    rdy[k] = 1'b0;
    repeat (2) @(negedge clk);
    log_q.delete();
    fin_cyc[k]  = -1;
    req0_cyc[k] = -1;
    rst[k] = 1'b0;
    rdy[k] = 1'b1;
  endtask

  task automatic wait_finish(input int k, input int budget, input string tag);
    int i;
    for (i = 0; i < budget && fin[k] !== 1'b1; i++) @(negedge clk);
    if (fin[k] !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: finish=%b after %0d cycles, required 1", tag, fin[k], budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin rst[k] = 1'b1; rdy[k] = 1'b0; gdata[k] = 8'h00; end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (req[k] !== 1'b0 || gaddr[k] !== 14'd0 || lv[k] !== 1'b0 ||
          la[k] !== 14'd0 || ld[k] !== 8'h00 || fin[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: req=%b addr=%0d lv=%b la=%0d ld=%h fin=%b, required all 0",
                 k, req[k], gaddr[k], lv[k], la[k], ld[k], fin[k]);
      end
    end
  endtask

  task automatic test_ramp();
    int exp_a [4] = '{5, 6, 9, 10};
    int exp_c [4] = '{12, 13, 16, 17};
    for (int i = 0; i < 16; i++) mem[0][i] = 8'(i);
    start_frame(0);
    wait_finish(0, 200, "ramp");
    n_cmp++;
    if (log_q.size() != 4) begin
      n_bad++; $display("FAIL ramp_count: got %0d strobes, required 4", log_q.size());
    end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      n_cmp++;
      if (log_q[i].addr != exp_a[i] || log_q[i].data != 8'hF0 ||
          log_q[i].cyc != req0_cyc[0] + exp_c[i]) begin
        n_bad++;
        $display("FAIL ramp_strobe[%0d]: addr=%0d data=%h dcyc=%0d, required addr=%0d data=f0 dcyc=%0d",
                 i, log_q[i].addr, log_q[i].data, log_q[i].cyc - req0_cyc[0], exp_a[i], exp_c[i]);
      end
    end
    n_cmp++;
    if (fin_cyc[0] != req0_cyc[0] + 18) begin
      n_bad++; $display("FAIL ramp_finish: dcyc=%0d, required 18", fin_cyc[0] - req0_cyc[0]);
    end
    rst[0] = 1'b1;
  endtask

  task automatic test_stall();
    int exp_a [4] = '{5, 6, 9, 10};
    int exp_c [4] = '{15, 16, 19, 20};
    int i;
    start_frame(0);
    for (i = 0; i < 50 && !(req[0] === 1'b1 && gaddr[0] == 14'd6); i++) @(negedge clk);
    @(negedge clk);
    rdy[0] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      n_cmp++;
      if (req[0] !== 1'b0 || gaddr[0] !== 14'd7) begin
        n_bad++; $display("FAIL stall_hold[%0d]: req=%b addr=%0d, required req=0 addr=7", j, req[0], gaddr[0]);
      end
      @(negedge clk);
    end
    rdy[0] = 1'b1;
    wait_finish(0, 200, "stall");
    n_cmp++;
    if (log_q.size() != 4) begin
      n_bad++; $display("FAIL stall_count: got %0d strobes, required 4", log_q.size());
    end
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      n_cmp++;
      if (log_q[k].addr != exp_a[k] || log_q[k].data != 8'hF0 ||
          log_q[k].cyc != req0_cyc[0] + exp_c[k]) begin
        n_bad++;
        $display("FAIL stall_strobe[%0d]: addr=%0d data=%h dcyc=%0d, required addr=%0d data=f0 dcyc=%0d",
                 k, log_q[k].addr, log_q[k].data, log_q[k].cyc - req0_cyc[0], exp_a[k], exp_c[k]);
      end
    end
    n_cmp++;
    if (fin_cyc[0] != req0_cyc[0] + 21) begin
      n_bad++; $display("FAIL stall_finish: dcyc=%0d, required 21", fin_cyc[0] - req0_cyc[0]);
    end
    rst[0] = 1'b1;
  endtask

  task automatic test_border();
    int exp_d;
    for (int i = 0; i < 16; i++) mem[1][i] = 8'(i);
    start_frame(1);
    wait_finish(1, 200, "border");
    n_cmp++;
    if (log_q.size() != 16) begin
      n_bad++; $display("FAIL border_count: got %0d strobes, required 16", log_q.size());
    end
    for (int i = 0; i < 16 && i < log_q.size(); i++) begin
      exp_d = (i == 5 || i == 6 || i == 9 || i == 10) ? 8'hF0 : 8'h00;
      n_cmp++;
      if (log_q[i].addr != i || log_q[i].data != exp_d || log_q[i].cyc != req0_cyc[1] + 7 + i) begin
        n_bad++;
        $display("FAIL border_strobe[%0d]: addr=%0d data=%h dcyc=%0d, required addr=%0d data=%h dcyc=%0d",
                 i, log_q[i].addr, log_q[i].data, log_q[i].cyc - req0_cyc[1], i, exp_d, 7 + i);
      end
    end
    n_cmp++;
    if (fin_cyc[1] != req0_cyc[1] + 23) begin
      n_bad++; $display("FAIL border_finish: dcyc=%0d, required 23", fin_cyc[1] - req0_cyc[1]);
    end
    rst[1] = 1'b1;
  endtask

  task automatic test_random();
    int idx;
    int pa [3] = '{18, 45, 21};
    int pv [3] = '{8'h01, 8'hFF, 8'h80};
    int n9 [8] = '{-9, -8, -7, -1, 1, 7, 8, 9};
    for (int i = 0; i < 64; i++) mem[2][i] = 8'($urandom_range(0, 255));
    // (2,2)=255 over zeros except (1,1)=255; (5,5)=0 under 255s; (2,5)=100 over 99s except (3,6)=100
    for (int b = 0; b < 8; b++) begin
      mem[2][18 + n9[b]] = 8'd0;
      mem[2][45 + n9[b]] = 8'd255;
      mem[2][21 + n9[b]] = 8'd99;
    end
    mem[2][18] = 8'd255; mem[2][9]  = 8'd255;
    mem[2][45] = 8'd0;
    mem[2][21] = 8'd100; mem[2][30] = 8'd100;
    start_frame(2);
    wait_finish(2, 400, "random");
    n_cmp++;
    if (log_q.size() != 36) begin
      n_bad++; $display("FAIL random_count: got %0d strobes, required 36", log_q.size());
    end
    idx = 0;
    for (int r = 1; r < 7; r++) begin
      for (int c = 1; c < 7; c++) begin
        if (idx < log_q.size()) begin
          n_cmp++;
          if (log_q[idx].addr != r * 8 + c || log_q[idx].data != int'(ref_code(2, r, c))) begin
            n_bad++;
            $display("FAIL random_strobe[%0d]: addr=%0d data=%h, required addr=%0d data=%h",
                     idx, log_q[idx].addr, log_q[idx].data, r * 8 + c, ref_code(2, r, c));
          end
        end
        idx++;
      end
    end
    for (int j = 0; j < 3; j++) begin
      idx = -1;
      for (int i = 0; i < log_q.size(); i++) if (log_q[i].addr == pa[j]) idx = i;
      n_cmp++;
      if (idx < 0 || log_q[idx].data != pv[j]) begin
        n_bad++;
        $display("FAIL random_planted[%0d]: addr %0d data=%h, required %h",
                 j, pa[j], (idx < 0) ? -1 : log_q[idx].data, pv[j]);
      end
    end
    rst[2] = 1'b1;
  endtask

  task automatic test_reset_mid_read();
    int i;
    int idx;
    for (int k = 0; k < 64; k++) mem[2][k] = 8'($urandom_range(0, 255));
    start_frame(2);
    for (i = 0; i < 100 && !(req[2] === 1'b1 && gaddr[2] == 14'd20); i++) @(negedge clk);
    n_cmp++;
    if (!(req[2] === 1'b1 && gaddr[2] == 14'd20)) begin
      n_bad++; $display("FAIL midreset_reach: addr=%0d, required request at 20", gaddr[2]);
    end
    rst[2] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req[2] !== 1'b0 || gaddr[2] !== 14'd0 || lv[2] !== 1'b0 ||
        la[2] !== 14'd0 || ld[2] !== 8'h00 || fin[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_state: req=%b addr=%0d lv=%b la=%0d ld=%h fin=%b, required all 0",
               req[2], gaddr[2], lv[2], la[2], ld[2], fin[2]);
    end
    log_q.delete();
    fin_cyc[2] = -1;
    rst[2] = 1'b0;
    for (i = 0; i < 20 && req[2] !== 1'b1; i++) @(negedge clk);
    n_cmp++;
    if (req[2] !== 1'b1 || gaddr[2] !== 14'd0) begin
      n_bad++; $display("FAIL midreset_restart: req=%b addr=%0d, required req=1 addr=0", req[2], gaddr[2]);
    end
    wait_finish(2, 400, "midreset");
    n_cmp++;
    if (log_q.size() != 36) begin
      n_bad++; $display("FAIL midreset_count: got %0d strobes, required 36", log_q.size());
    end
    idx = 0;
    for (int r = 1; r < 7; r++) begin
      for (int c = 1; c < 7; c++) begin
        if (idx < log_q.size()) begin
          n_cmp++;
          if (log_q[idx].addr != r * 8 + c || log_q[idx].data != int'(ref_code(2, r, c))) begin
            n_bad++;
            $display("FAIL midreset_strobe[%0d]: addr=%0d data=%h, required addr=%0d data=%h",
                     idx, log_q[idx].addr, log_q[idx].data, r * 8 + c, ref_code(2, r, c));
          end
        end
        idx++;
      end
    end
    rst[2] = 1'b1;
  endtask

  task automatic test_const_default();
    int idx;
    int bad;
    for (int i = 0; i < 16384; i++) mem[3][i] = 8'h55;
    start_frame(3);
    wait_finish(3, 20000, "const");
    n_cmp++;
    if (log_q.size() != 126 * 126) begin
      n_bad++; $display("FAIL const_count: got %0d strobes, required %0d", log_q.size(), 126 * 126);
    end
    idx = 0;
    bad = 0;
    for (int r = 1; r < 127; r++) begin
      for (int c = 1; c < 127; c++) begin
        if (idx >= log_q.size() || log_q[idx].addr != r * 128 + c || log_q[idx].data != 8'hFF) bad++;
        idx++;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL const_strobes: %0d strobes wrong in addr/data, required 0", bad);
    end
    n_cmp++;
    if (log_q.size() > 0 && fin_cyc[3] != log_q[log_q.size() - 1].cyc + 1) begin
      n_bad++; $display("FAIL const_finish: finish cyc=%0d, required %0d", fin_cyc[3],
                        log_q[log_q.size() - 1].cyc + 1);
    end
    rst[3] = 1'b1;
  endtask

  // Global time bound.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Test sequence.
  initial begin
    for (int k = 0; k < 4; k++) begin fin_cyc[k] = -1; req0_cyc[k] = -1; end
    test_reset();
    test_ramp();
    test_stall();
    test_border();
    test_random();
    test_reset_mid_read();
    test_const_default();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lbp_stream.md
Name: lbp_stream

Overview:
- Parametrised streaming Local Binary Pattern engine for the gray-image LBP path.
- Fetches each gray pixel exactly once, in raster order. Two line buffers plus a 3x3 window register replace the per-pixel 9-read scheme.
- Writes one 8-bit LBP code per output pixel to the LBP memory port.
- Adds configurable image size, pixel width, border handling, and stall-tolerant fetch.

Parameters:
- IMG_W, 128: image width in pixels, 3 to 1024.
- IMG_H, 128: image height in pixels, at least 3.
- DW, 8: gray pixel width in bits.
- AW, 14: address width; must satisfy 2^AW >= IMG_W*IMG_H.
- BORDER, 0: 0 = emit interior pixels only; 1 = emit every pixel, with border pixels coded 0.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- gray_ready  in  1  gray memory available; level signal, may drop at any time.
- gray_req  out  1  read request, valid with gray_addr this cycle.
- gray_addr  out  AW  gray read address.
- gray_data  in  DW  read data, returned one cycle after the accepted request.
- lbp_valid  out  1  one-cycle write strobe for lbp_addr/lbp_data.
- lbp_addr  out  AW  LBP write address, equal to the center pixel index r*IMG_W+c.
- lbp_data  out  8  LBP code.
- finish  out  1  frame complete; sticky until reset.

Behaviour:
- Reset values: gray_req=0, gray_addr=0, lbp_valid=0, lbp_addr=0, lbp_data=0, finish=0. All counters, line buffers and window registers are cleared; state=IDLE.
- Reset is honoured in any state, including mid-frame and in DONE. The next frame restarts from address 0.
- IDLE -> READ on the first cycle gray_ready=1.
- READ:
  - Each cycle with gray_ready=1: gray_req=1 and gray_addr=p, where p is the fetch index.
  - p increments by 1 each accepted cycle.
  - Cycle with gray_ready=0: gray_req=0, gray_addr and p hold. The data for the previously accepted request is still captured.
- READ -> DRAIN after the request for p=IMG_W*IMG_H-1 is accepted.
- Data path: when the pixel with index p arrives, it is shifted into the window and line buffers. The window then covers rows r-1..r+1 and columns c-1..c+1 around the center q=p-IMG_W-1.
- Code bits (set when neighbour >= center, unsigned compare):
  - bit0: (r-1,c-1); bit1: (r-1,c); bit2: (r-1,c+1)
  - bit3: (r,c-1); bit4: (r,c+1)
  - bit5: (r+1,c-1); bit6: (r+1,c); bit7: (r+1,c+1)
- Latency: request at cycle t, data at t+1, lbp_valid/addr/data registered at t+2.
- Interior center (1<=r<=IMG_H-2 and 1<=c<=IMG_W-2): emit the code at lbp_addr=q.
- Border center:
  - BORDER=0: no strobe.
  - BORDER=1: strobe with data 0.
  - Centers q<0 are never emitted.
- DRAIN:
  - BORDER=1: emits zero codes for q=IMG_W*IMG_H-IMG_W-1 .. IMG_W*IMG_H-1, one per cycle, independent of gray_ready.
  - BORDER=0: DRAIN lasts only until the final pipelined strobe has been issued.
- DRAIN -> DONE after the last strobe. finish=1 on the cycle after the last lbp_valid and stays high; gray_req stays 0.
- Output order is strictly ascending lbp_addr.
  - BORDER=1: exactly IMG_W*IMG_H strobes covering 0..IMG_W*IMG_H-1.
  - BORDER=0: exactly (IMG_W-2)*(IMG_H-2) strobes.
- Stalls freeze the window and line buffers; no strobe is produced for a stalled data slot.
- Row wrap: windows that straddle rows are suppressed (BORDER=0) or zeroed (BORDER=1) by the column check; they never produce a nonzero code.
- Width rules:
  - p and q counters are AW bits; column and row counters are ceil(log2) of IMG_W and IMG_H.
  - No arithmetic overflow is allowed for legal parameters.

Test Plan:
- IMG_W=IMG_H=4, BORDER=0, gray[i]=i, gray_ready held 1 -> 4 strobes at addr 5, 6, 9, 10, each with data 0xF0; finish rises 1 cycle after the last strobe.
- Default 128x128, constant image 0x55 -> 126*126 strobes, all data 0xFF, addresses 129..16254 skipping columns 0 and 127.
- 4x4, BORDER=1, ramp image -> 16 strobes at addr 0..15 in order; addr 5, 6, 9, 10 = 0xF0, all others 0x00.
- 4x4 ramp with gray_ready low for 3 cycles after request 6 -> gray_req=0 and gray_addr held at 7 during the stall; results identical to the first test, strobes shifted by 3 cycles.
- 8x8 random image, DW=8 -> every strobe matches the reference model; center equal to a neighbour sets that bit; 255 vs 0 extremes checked.
- Reset asserted mid-READ at p=20 -> next cycle all outputs are 0; after release, the frame restarts at gray_addr 0 and produces a full correct result set.
